sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
Front-end stage that conditions raw sensor signals before the round-robin home monitor/alarm sequencer consumes them.
- Binary sensors (front door, rear door, window, fire alarm): synchronised and debounced.
- 7-bit temperature: sampled at a fixed rate and averaged over 4 samples.
- Outputs are the clean SFD, SRD, SW, SFA, ST inputs of the sequencer, plus change strobes and a temperature-valid flag.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronised cycles required before a binary output changes (legal range 2..255)
SAMPLE_DIV, 8, Clk cycles between temperature samples (legal range 2..255)
SPIKE_LIM, 16, max |sample − ST| accepted when ST_SPIKE_REJECT_EN is defined

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
raw_sfd  in  1  front-door switch, asynchronous
raw_srd  in  1  rear-door switch, asynchronous
raw_sw  in  1  window switch, asynchronous
raw_sfa  in  1  fire-alarm contact, asynchronous
raw_st  in  7  temperature code, synchronous to Clk (ADC in same domain)
SFD  out  1  debounced front door
SRD  out  1  debounced rear door
SW  out  1  debounced window
SFA  out  1  debounced fire alarm
ST  out  7  averaged temperature
st_valid  out  1  ST holds a real 4-sample average
chg  out  4  1-cycle toggle strobes, bit order {SFD,SRD,SFA,SW}
st_fault  out  1  present only with ST_SPIKE_REJECT_EN; 1-cycle pulse per rejected sample

Behaviour:
- Reset is synchronous: Rst sampled high at a Clk edge sets all of the following on that edge.
  - SFD, SRD, SW, SFA, chg, st_valid, st_fault = 0.
  - ST = 7'd60 (inside the 50..70 comfort band, so downstream heater/cooler stay off).
  - Synchronisers, debounce counters, prescaler, sample buffer and sample count cleared.
- Reset takes priority over everything; a reset mid-debounce or mid-averaging discards all partial state.
- Binary channels (identical, independent):
  - 2-flop synchroniser.
  - 8-bit counter cnt. If synced != output: cnt increments. Otherwise cnt = 0.
  - When a mismatch is seen with cnt == DEB_CYCLES−1: output toggles, cnt = 0, and the chg bit pulses high that same cycle.
  - Latency from a clean raw edge to output change is exactly DEB_CYCLES+2 Clk edges.
  - A glitch shorter than DEB_CYCLES synced cycles causes no output change.
  - chg bits are never held high for more than 1 cycle.
- Temperature path:
  - raw_st is registered once.
  - Prescaler counts 0..SAMPLE_DIV−1 and wraps. At terminal count a sample tick occurs.
  - On a sample tick, the registered value shifts into a 4-entry buffer; the oldest entry is dropped.
  - Sample count saturates at 4.
  - Sum is computed 9 bits wide. Average = sum >> 2 (truncate). No overflow is possible: max 4×127 = 508.
  - ST updates on the cycle after each accepted tick, and only once sample count == 4.
  - st_valid rises together with the first ST update and stays high until reset.
  - Before st_valid is high, ST holds 60.
  - First valid ST appears 4×SAMPLE_DIV+2 cycles after reset release.

Optional Feature:
Macro ST_SPIKE_REJECT_EN.
- With the macro:
  - While st_valid = 1, a sample with |sample − ST| > SPIKE_LIM is not shifted in, and st_fault pulses.
  - After 3 consecutive rejections, the 4th out-of-range sample is accepted and the rejection counter clears. This tracks real step changes.
  - Any accepted sample clears the rejection counter.
  - Before st_valid, all samples are accepted.
- Without the macro: every sample is accepted and the st_fault port does not exist.

Decomposition:
- Package home_pkg holds:
  - ST_RESET = 60, T_LOW = 50, T_HIGH = 70.
  - TEMP_W = 7.
  - Channel index constants CH_SFD = 3, CH_SRD = 2, CH_SFA = 1, CH_SW = 0.
  - Type temp_t (7-bit).
- Sub-module debounce_ch: synchroniser + counter + toggle strobe, parameterised by DEB_CYCLES. Instantiated 4×.
- Temperature averaging stays in the top level.

Test Plan:
1. Reset check: hold Rst 3 cycles with random raw inputs → SFD/SRD/SW/SFA = 0, ST = 60, st_valid = 0, chg = 0 during and immediately after reset.
2. Clean edge, DEB_CYCLES=4: raw_sfd 0→1 held → SFD rises exactly 6 edges later, with chg = 4'b1000 for 1 cycle; other channels unchanged.
3. Bounce rejection, DEB_CYCLES=4: raw_sw high 3 cycles then low → SW stays 0, chg stays 0, counter returns to 0.
4. Averaging, SAMPLE_DIV=8: raw_st = 40 constant from reset → st_valid and ST = 40 at cycle 34. Then raw_st = 80 → ST goes 50, 60, 70, 80 on successive ticks.
5. Reset mid-operation: assert Rst while SFA debounce cnt = 2 and 3 samples are buffered → ST = 60, st_valid = 0; full 4-sample / DEB latency restarts.
6. ST_SPIKE_REJECT_EN, ST = 40 valid: single sample 100 → st_fault pulse, ST unchanged. Then 4 consecutive samples of 100 → 3 st_fault pulses, 4th accepted, ST = 55.

Source files
------------

// File: rtl/home_pkg.sv
// Shared constants and types for the home monitor sensor front end.
// Channel indices fix the bit order of the chg strobe vector.
package home_pkg;

    localparam int TEMP_W = 7;

    typedef logic [TEMP_W-1:0] temp_t;

    localparam temp_t ST_RESET = 7'd60;
    localparam temp_t T_LOW    = 7'd50;
    localparam temp_t T_HIGH   = 7'd70;

    localparam int CH_SFD = 3;
    localparam int CH_SRD = 2;
    localparam int CH_SFA = 1;
    localparam int CH_SW  = 0;

endpackage

// File: rtl/debounce_ch.sv
// One binary sensor channel: 2-flop synchroniser, stability counter
// and a single-cycle strobe whenever the clean output toggles.
module debounce_ch #(
    parameter int DEB_CYCLES = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic raw,
    output logic q,
    output logic chg
);

    logic       s1;
    logic       s2;
    logic [7:0] cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            q   <= 1'b0;
            chg <= 1'b0;
            cnt <= 8'd0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            chg <= 1'b0;
            if (s2 != q) begin
                if (cnt == 8'(DEB_CYCLES - 1)) begin
                    q   <= ~q;
                    chg <= 1'b1;
                    cnt <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: debounced door/window/fire inputs and a 4-sample
// temperature average. ST_SPIKE_REJECT_EN adds spike rejection + st_fault.
module sensor_conditioner
    import home_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int SAMPLE_DIV = 8
`ifdef ST_SPIKE_REJECT_EN
    ,
    parameter int SPIKE_LIM  = 16
`endif
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              raw_sfd,
    input  logic              raw_srd,
    input  logic              raw_sw,
    input  logic              raw_sfa,
    input  logic [TEMP_W-1:0] raw_st,
    output logic              SFD,
    output logic              SRD,
    output logic              SW,
    output logic              SFA,
    output logic [TEMP_W-1:0] ST,
    output logic              st_valid,
`ifdef ST_SPIKE_REJECT_EN
    output logic              st_fault,
`endif
    output logic [3:0]        chg
);

    logic [3:0] raw_v;
    logic [3:0] deb_v;
    logic [3:0] chg_v;

    assign raw_v[CH_SFD] = raw_sfd;
    assign raw_v[CH_SRD] = raw_srd;
    assign raw_v[CH_SFA] = raw_sfa;
    assign raw_v[CH_SW]  = raw_sw;

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_sfd (
        .Clk (Clk),
        .Rst (Rst),
        .raw (raw_v[CH_SFD]),
        .q   (deb_v[CH_SFD]),
        .chg (chg_v[CH_SFD])
    );

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_srd (
        .Clk (Clk),
        .Rst (Rst),
        .raw (raw_v[CH_SRD]),
        .q   (deb_v[CH_SRD]),
        .chg (chg_v[CH_SRD])
    );

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_sfa (
        .Clk (Clk),
        .Rst (Rst),
        .raw (raw_v[CH_SFA]),
        .q   (deb_v[CH_SFA]),
        .chg (chg_v[CH_SFA])
    );

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_sw (
        .Clk (Clk),
        .Rst (Rst),
        .raw (raw_v[CH_SW]),
        .q   (deb_v[CH_SW]),
        .chg (chg_v[CH_SW])
    );

    assign SFD = deb_v[CH_SFD];
    assign SRD = deb_v[CH_SRD];
    assign SFA = deb_v[CH_SFA];
    assign SW  = deb_v[CH_SW];
    assign chg = chg_v;

    temp_t                  st_r;
    logic [7:0]             pcnt;
    logic                   tick_q;
    logic                   acc_q;
    logic [3:0][TEMP_W-1:0] sbuf;
    logic [2:0]             scnt;
    logic [8:0]             sum;
    logic                   accept;

    always_comb begin
        sum = 9'(sbuf[0]) + 9'(sbuf[1]) + 9'(sbuf[2]) + 9'(sbuf[3]);
    end

`ifdef ST_SPIKE_REJECT_EN
    temp_t      diff;
    logic       spike;
    logic [1:0] rej_cnt;

    // A run of 3 rejections lets the 4th through, so real steps are tracked
    always_comb begin
        diff   = (st_r >= ST) ? (st_r - ST) : (ST - st_r);
        spike  = st_valid && (int'(diff) > SPIKE_LIM);
        accept = !spike || (rej_cnt == 2'd3);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rej_cnt  <= 2'd0;
            st_fault <= 1'b0;
        end else begin
            st_fault <= 1'b0;
            if (tick_q) begin
                if (accept) begin
                    rej_cnt <= 2'd0;
                end else begin
                    rej_cnt  <= rej_cnt + 2'd1;
                    st_fault <= 1'b1;
                end
            end
        end
    end
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st_r     <= '0;
            pcnt     <= 8'd0;
            tick_q   <= 1'b0;
            acc_q    <= 1'b0;
            sbuf     <= '0;
            scnt     <= 3'd0;
            ST       <= ST_RESET;
            st_valid <= 1'b0;
        end else begin
            st_r   <= raw_st;
            tick_q <= (pcnt == 8'(SAMPLE_DIV - 1));
            acc_q  <= 1'b0;
            if (pcnt == 8'(SAMPLE_DIV - 1)) begin
                pcnt <= 8'd0;
            end else begin
                pcnt <= pcnt + 8'd1;
            end
            if (tick_q && accept) begin
                sbuf  <= {sbuf[2:0], st_r};
                acc_q <= 1'b1;
                if (scnt != 3'd4) begin
                    scnt <= scnt + 3'd1;
                end
            end
            // Publish only once the buffer holds 4 real samples
            if (acc_q && (scnt == 3'd4)) begin
                ST       <= sum[8:2];
                st_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner (DEB_CYCLES=4, SAMPLE_DIV=8).
// Also exercises spike rejection when ST_SPIKE_REJECT_EN is defined.
module tb_sensor_conditioner;
    import home_pkg::*;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] rawv;
    logic [6:0] raw_st;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       st_valid;
    logic [3:0] chg;
`ifdef ST_SPIKE_REJECT_EN
    logic       st_fault;
`endif

    always #5 Clk = ~Clk;

    wire [3:0] outv = {SFD, SRD, SFA, SW};

    sensor_conditioner #(
        .DEB_CYCLES (DEB),
        .SAMPLE_DIV (DIV)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .raw_sfd  (rawv[CH_SFD]),
        .raw_srd  (rawv[CH_SRD]),
        .raw_sw   (rawv[CH_SW]),
        .raw_sfa  (rawv[CH_SFA]),
        .raw_st   (raw_st),
        .SFD      (SFD),
        .SRD      (SRD),
        .SW       (SW),
        .SFA      (SFA),
        .ST       (ST),
        .st_valid (st_valid),
`ifdef ST_SPIKE_REJECT_EN
        .st_fault (st_fault),
`endif
        .chg      (chg)
    );

    int total = 0;
    int bad   = 0;
    int chg_cnt [4];
    int dbl;
    int faults;
    logic [3:0] prev_chg;
    int exp_q [$];

    typedef struct {
        int    ch;
        int    len;
        bit    tog;
        string nm;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 4; i++) chg_cnt[i] = 0;
        dbl      = 0;
        faults   = 0;
        prev_chg = 4'b0;
    endtask

    task automatic step();
        @(negedge Clk);
        for (int i = 0; i < 4; i++) chg_cnt[i] += int'(chg[i]);
        if ((chg & prev_chg) != 4'b0) dbl++;
        prev_chg = chg;
`ifdef ST_SPIKE_REJECT_EN
        faults += int'(st_fault);
`endif
    endtask

    task automatic wait_st_change(output bit ok);
        logic [6:0] old;
        int n;
        old = ST;
        n   = 0;
        while (ST == old && n < 20) begin
            step();
            n++;
        end
        ok = (ST != old);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   stepv;
        int   others;
        bit   ok;
        logic lvl;

        vt[0] = '{CH_SW,  3, 1'b0, "sw_bounce3"};
        vt[1] = '{CH_SW,  1, 1'b0, "sw_glitch1"};
        vt[2] = '{CH_SRD, 4, 1'b1, "srd_rise"};
        vt[3] = '{CH_SFA, 2, 1'b0, "sfa_glitch2"};
        vt[4] = '{CH_SRD, 4, 1'b1, "srd_fall"};
        vt[5] = '{CH_SFD, 5, 1'b1, "sfd_fall"};
        vt[6] = '{CH_SW,  6, 1'b1, "sw_rise"};

        // Reset with random binary inputs
        Rst    = 1'b1;
        rawv   = 4'($urandom);
        raw_st = 7'd40;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            step();
            rawv = 4'($urandom);
            check("rst_bin", int'(outv), 0);
            check("rst_st", int'(ST), 60);
            check("rst_valid", int'(st_valid), 0);
            check("rst_chg", int'(chg), 0);
        end
        Rst  = 1'b0;
        rawv = 4'b0;

        // First average after 4*DIV+2 edges
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k == 1) begin
                check("post_rst_bin", int'(outv), 0);
                check("post_rst_chg", int'(chg), 0);
            end
            if (k == 33) begin
                check("avg_early_valid", int'(st_valid), 0);
                check("avg_early_st", int'(ST), 60);
            end
            if (k == 34) begin
                check("avg_first_valid", int'(st_valid), 1);
                check("avg_first_st", int'(ST), 40);
            end
        end

        // Step response through the scoreboard
`ifdef ST_SPIKE_REJECT_EN
        stepv = 50;
        exp_q.push_back(42);
        exp_q.push_back(45);
        exp_q.push_back(47);
        exp_q.push_back(50);
`else
        stepv = 80;
        exp_q.push_back(50);
        exp_q.push_back(60);
        exp_q.push_back(70);
        exp_q.push_back(80);
`endif
        raw_st = 7'(stepv);
        while (exp_q.size() > 0) begin
            wait_st_change(ok);
            check("avg_step_timeout", int'(ok), 1);
            check("avg_step_st", int'(ST), exp_q.pop_front());
        end

        // Clean edge on front door
        clear_mon();
        rawv[CH_SFD] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 5) check("sfd_early", int'(SFD), 0);
            if (k == 6) begin
                check("sfd_edge", int'(SFD), 1);
                check("sfd_chg", int'(chg), 8);
            end
            if (k == 7) check("sfd_chg_off", int'(chg), 0);
        end
        check("sfd_others", int'(outv[2:0]), 0);
        check("sfd_dbl", dbl, 0);

        // Table of pulses per channel
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            lvl = outv[vt[i].ch];
            rawv[vt[i].ch] = ~lvl;
            repeat (vt[i].len) step();
            if (!vt[i].tog) rawv[vt[i].ch] = lvl;
            repeat (DEB + 6) step();
            others = chg_cnt[0] + chg_cnt[1] + chg_cnt[2] + chg_cnt[3]
                     - chg_cnt[vt[i].ch];
            check({vt[i].nm, "_lvl"}, int'(outv[vt[i].ch]), int'(lvl ^ vt[i].tog));
            check({vt[i].nm, "_chg"}, chg_cnt[vt[i].ch], int'(vt[i].tog));
            check({vt[i].nm, "_other"}, others, 0);
            check({vt[i].nm, "_dbl"}, dbl, 0);
            if (i == 0) check("sw_bounce_cnt", int'(dut.u_sw.cnt), 0);
        end

        // Reset in the middle of debounce and averaging
        rawv   = 4'b0;
        raw_st = 7'd40;
        Rst    = 1'b1;
        step();
        Rst = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 22) rawv[CH_SFA] = 1'b1;
        end
        check("mid_setup_cnt", int'(dut.u_sfa.cnt), 2);
        check("mid_setup_scnt", int'(dut.scnt), 3);
        Rst = 1'b1;
        step();
        check("mid_rst_st", int'(ST), 60);
        check("mid_rst_valid", int'(st_valid), 0);
        check("mid_rst_sfa", int'(SFA), 0);
        Rst = 1'b0;
        clear_mon();
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k == 5) check("mid_sfa_early", int'(SFA), 0);
            if (k == 6) begin
                check("mid_sfa_edge", int'(SFA), 1);
                check("mid_sfa_chg", int'(chg), 2);
            end
            if (k == 33) check("mid_valid_early", int'(st_valid), 0);
            if (k == 34) begin
                check("mid_valid", int'(st_valid), 1);
                check("mid_st", int'(ST), 40);
            end
        end

`ifdef ST_SPIKE_REJECT_EN
        // Single spike rejected, then a sustained step gets through
        raw_st = 7'd100;
        faults = 0;
        begin
            int n;
            n = 0;
            while (faults == 0 && n < 20) begin
                step();
                n++;
            end
        end
        check("spike_fault", faults, 1);
        check("spike_hold", int'(ST), 40);
        raw_st = 7'd40;
        repeat (8) step();
        check("spike_recover", faults, 1);
        raw_st = 7'd100;
        faults = 0;
        repeat (34) step();
        check("spike_run_faults", faults, 3);
        check("spike_run_st", int'(ST), 55);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
